// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue controller.
//   - opcode and logic sub-select constants understood by alu_top
//   - alu_cmd_t: 13-bit buffered command {a, b, opcode, logic_sel}
//   - issue_state_t: issue FSM states
//   - is_div0(): flags a divide/modulo command whose divisor is zero
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ROR   = 3'b110;
  localparam logic [2:0] OP_MOD   = 3'b111;

  localparam logic [1:0] LS_AND = 2'b00;
  localparam logic [1:0] LS_OR  = 2'b01;
  localparam logic [1:0] LS_XOR = 2'b10;
  localparam logic [1:0] LS_NOT = 2'b11;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic [1:0] logic_sel;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } issue_state_t;

  function automatic logic is_div0(input logic [2:0] opcode, input logic [3:0] b);
    return ((opcode == OP_DIV) || (opcode == OP_MOD)) && (b == 4'h0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous FIFO of alu_cmd_t.
//   push/push_data : write side, ignored while full
//   pop/pop_data   : read side, pop_data is the current head (show-ahead)
//   full/empty     : occupancy flags
//   count          : occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  alu_cmd_t                 push_data,
  input  logic                     pop,
  output alu_cmd_t                 pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  alu_cmd_t         mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == (PTR_W+1)'(1'b0));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage write; entries need no reset because count_r gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(1'b0);
      rd_ptr_r <= PTR_W'(1'b0);
      count_r  <= (PTR_W+1)'(1'b0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command buffer and issue controller in front of alu_top.
//   cmd_*        : command input handshake (valid/ready) with operands
//   alu_*        : operands to the combinational alu_top, result back in
//   rsp_*        : registered result and its opcode, valid/ready handshake
//   fifo_count   : buffered commands, 0..DEPTH
//   rsp_err      : only when ALU_ISSUE_DIV0_FLAG_EN is defined; flags
//                  DIV/MOD by zero, held alongside rsp_result
// Capacity is DEPTH buffered commands plus one in the operand registers.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [2:0]               cmd_opcode,
  input  logic [1:0]               cmd_logic_sel,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_opcode,
  output logic [1:0]               alu_logic_sel,
  input  logic [7:0]               alu_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_result,
  output logic [2:0]               rsp_opcode,
`ifdef ALU_ISSUE_DIV0_FLAG_EN
  output logic                     rsp_err,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  issue_state_t state_r;
  alu_cmd_t     op_r;
  alu_cmd_t     head_s;
  alu_cmd_t     cmd_s;
  logic         full_s;
  logic         empty_s;
  logic         push_s;
  logic         pop_s;
  logic         rsp_valid_r;
  logic [7:0]   rsp_result_r;
  logic [2:0]   rsp_opcode_r;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
  logic         rsp_err_r;
`endif

  assign cmd_s     = '{a: cmd_a, b: cmd_b, opcode: cmd_opcode, logic_sel: cmd_logic_sel};
  assign cmd_ready = !full_s;
  assign push_s    = cmd_valid && !full_s;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (cmd_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count)
  );

  // Pop the head whenever the operand registers are free: in IDLE, or in
  // RESP on the cycle the current response is accepted.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = !empty_s;
      RESP:    pop_s = rsp_ready && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Issue FSM: operand registers, result capture and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_r         <= '{a: 4'h0, b: 4'h0, opcode: 3'b000, logic_sel: 2'b00};
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 8'h00;
      rsp_opcode_r <= 3'b000;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
      rsp_err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (!empty_s) begin
            op_r    <= head_s;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_r <= alu_result;
          rsp_opcode_r <= op_r.opcode;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
          rsp_err_r    <= is_div0(op_r.opcode, op_r.b);
`endif
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (!empty_s) begin
              op_r    <= head_s;
              state_r <= EXEC;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a         = op_r.a;
  assign alu_b         = op_r.b;
  assign alu_opcode    = op_r.opcode;
  assign alu_logic_sel = op_r.logic_sel;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_result    = rsp_result_r;
  assign rsp_opcode    = rsp_opcode_r;
`ifdef ALU_ISSUE_DIV0_FLAG_EN
  assign rsp_err       = rsp_err_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl.
// A behavioural alu_top model closes the alu_* loop. Every accepted command
// pushes its expected response onto a scoreboard queue; every response
// handshake pops and compares. Directed phases cover latency, streaming
// throughput, back-pressure/capacity, divide-by-zero, mid-run reset and
// simultaneous push/pop with pointer wrap, followed by a random phase.
// Honours ALU_ISSUE_DIV0_FLAG_EN for the rsp_err port.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] result;
    logic [2:0] opcode;
    logic       err;
  } rsp_exp_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_opcode;
  logic [1:0] cmd_logic_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [1:0] alu_logic_sel;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [2:0] rsp_opcode;
  logic       rsp_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int       n_checks;
  int       n_fail;
  int       cyc;
  rsp_exp_t exp_q[$];

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_opcode    (cmd_opcode),
    .cmd_logic_sel (cmd_logic_sel),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_logic_sel (alu_logic_sel),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_opcode    (rsp_opcode),
`ifdef ALU_ISSUE_DIV0_FLAG_EN
    .rsp_err       (rsp_err),
`endif
    .fifo_count    (fifo_count)
  );

`ifndef ALU_ISSUE_DIV0_FLAG_EN
  assign rsp_err = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic [1:0] ls);
    logic [7:0] t;
    case (op)
      OP_ADD: return {4'h0, a} + {4'h0, b};
      OP_SUB: return {4'h0, a} - {4'h0, b};
      OP_LOGIC: begin
        case (ls)
          LS_AND:  return {4'h0, a & b};
          LS_OR:   return {4'h0, a | b};
          LS_XOR:  return {4'h0, a ^ b};
          default: return {4'h0, ~a};
        endcase
      end
      OP_DIV: return (b == 4'h0) ? 8'hFF : {4'h0, a / b};
      OP_MUL: return {4'h0, a} * {4'h0, b};
      OP_ROL: begin
        t = {a, a} << b[1:0];
        return {4'h0, t[7:4]};
      end
      OP_ROR: begin
        t = {a, a} >> b[1:0];
        return {4'h0, t[3:0]};
      end
      default: return (b == 4'h0) ? 8'hFF : {4'h0, a % b};
    endcase
  endfunction

  // Behavioural alu_top: combinational on the DUT's alu_* outputs.
  always_comb alu_result = alu_ref(alu_a, alu_b, alu_opcode, alu_logic_sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1'b1));
    check({tag, "_rsp"}, 32'({rsp_valid, rsp_result, rsp_opcode, rsp_err}), 32'(13'h0000));
    check({tag, "_alu"}, 32'({alu_a, alu_b, alu_opcode, alu_logic_sel}), 32'(13'h0000));
    check({tag, "_count"}, 32'(fifo_count), 32'(3'd0));
  endtask

  // Scoreboard: sample away from the rising edge; a handshake seen here
  // completes on the following rising edge.
  always @(negedge clk) begin : monitor
    rsp_exp_t e;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        e.result = alu_ref(cmd_a, cmd_b, cmd_opcode, cmd_logic_sel);
        e.opcode = cmd_opcode;
        e.err    = ((cmd_opcode == OP_DIV) || (cmd_opcode == OP_MOD)) && (cmd_b == 4'h0);
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(1'b1), 32'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(e.result));
          check("rsp_opcode", 32'(rsp_opcode), 32'(e.opcode));
`ifdef ALU_ISSUE_DIV0_FLAG_EN
          check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
        end
      end
    end
  end

  // Present one command and hold it until accepted; returns 1ns after the
  // accepting edge with cmd_valid dropped.
  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, input logic [1:0] ls);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_opcode = op;
    cmd_logic_sel = ls;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!acc) check("send_accept", 32'(acc), 32'(1'b1));
  endtask

  task automatic wait_valid(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) break;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic       seen;
    int         stamps[3];
    logic [7:0] stream_exp[3];
    int         nvalid;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 4'h0;
    cmd_b = 4'h0;
    cmd_opcode = 3'b000;
    cmd_logic_sel = 2'b00;
    rsp_ready = 1'b0;
    #22;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: ADD 3+4 into an empty idle block.
    rsp_ready = 1'b1;
    send(4'd3, 4'd4, OP_ADD, LS_AND);
    @(negedge clk);
    check("lat_n_count", 32'(fifo_count), 32'd1);
    check("lat_n_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_n1_count", 32'(fifo_count), 32'd0);
    check("lat_n1_valid", 32'(rsp_valid), 32'd0);
    check("lat_n1_alu", 32'({alu_a, alu_b, alu_opcode}), 32'({4'd3, 4'd4, OP_ADD}));
    @(negedge clk);
    check("lat_n2_valid", 32'(rsp_valid), 32'd1);
    check("lat_n2_result", 32'(rsp_result), 32'h07);
    check("lat_n2_opcode", 32'(rsp_opcode), 32'(OP_ADD));
    drain();

    // Streaming: three back-to-back commands, one result every 2 cycles.
    stream_exp[0] = 8'hE1;
    stream_exp[1] = 8'h04;
    stream_exp[2] = 8'h0E;
    fork
      begin
        send(4'hF, 4'hF, OP_MUL, LS_AND);
        send(4'h8, 4'h2, OP_DIV, LS_AND);
        send(4'hD, 4'h1, OP_ROR, LS_AND);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid(seen);
          check("stream_seen", 32'(seen), 32'd1);
          check("stream_value", 32'(rsp_result), 32'(stream_exp[k]));
          stamps[k] = cyc;
        end
      end
    join
    check("stream_gap01", 32'(stamps[1] - stamps[0]), 32'd2);
    check("stream_gap12", 32'(stamps[2] - stamps[1]), 32'd2);
    drain();

    // Back-pressure: 5 accepted (4 buffered + 1 in flight), 6th refused.
    rsp_ready = 1'b0;
    send(4'h1, 4'h2, OP_ADD, LS_AND);
    send(4'h2, 4'h7, OP_SUB, LS_AND);
    send(4'hC, 4'hA, OP_LOGIC, LS_XOR);
    send(4'h9, 4'h2, OP_ROL, LS_AND);
    send(4'h6, 4'h0, OP_LOGIC, LS_NOT);
    cmd_valid = 1'b1;
    cmd_a = 4'h5;
    cmd_b = 4'h5;
    cmd_opcode = OP_MUL;
    repeat (3) @(negedge clk);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_ready", 32'(cmd_ready), 32'd1);
    check("release_count", 32'(fifo_count), 32'(DEPTH - 1));
    drain();

    // Divide and modulo by zero.
    send(4'h5, 4'h0, OP_DIV, LS_AND);
    wait_valid(seen);
    check("div0_result", 32'(rsp_result), 32'hFF);
    send(4'h9, 4'h0, OP_MOD, LS_AND);
    send(4'h9, 4'h4, OP_MOD, LS_AND);
    drain();

    // Reset during RESP with 3 commands queued.
    rsp_ready = 1'b0;
    send(4'hA, 4'h5, OP_SUB, LS_OR);
    send(4'h3, 4'h3, OP_MUL, LS_AND);
    send(4'h7, 4'h1, OP_ROL, LS_AND);
    send(4'hE, 4'h2, OP_DIV, LS_AND);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid && fifo_count == 3) break;
    end
    check("rst_setup", 32'({rsp_valid, fifo_count}), 32'({1'b1, 3'd3}));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) nvalid++;
    end
    check("no_stale_rsp", 32'(nvalid), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;

    // Simultaneous push and pop with fifo_count == 2.
    rsp_ready = 1'b0;
    send(4'h1, 4'h1, OP_ADD, LS_AND);
    send(4'h2, 4'h3, OP_MUL, LS_AND);
    send(4'hB, 4'h2, OP_ROR, LS_AND);
    @(negedge clk);
    check("pp_pre_count", 32'({rsp_valid, fifo_count}), 32'({1'b1, 3'd2}));
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_a = 4'hF;
    cmd_b = 4'h3;
    cmd_opcode = OP_SUB;
    cmd_logic_sel = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd2);
    rsp_ready = 1'b1;
    drain();

    // Random traffic with random back-pressure; wraps pointers repeatedly.
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command buffer and issue controller that sits directly upstream of `alu_top`. It accepts ALU commands (A, B, opcode, logic_sel) over a valid/ready handshake and buffers them in a FIFO. It drives one command at a time onto the combinational ALU, registers the 8-bit result, and presents it downstream over a second valid/ready handshake, so the ALU can be used in a clocked, back-pressured datapath.

## Interface
- `DEPTH`, default 4: command FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_a`, `cmd_b` in 4: operands.
- `cmd_opcode` in 3: ALU opcode (000 ADD … 111 MOD).
- `cmd_logic_sel` in 2: logic sub-select, meaningful for opcode 010.
- `alu_a`, `alu_b` out 4: to `alu_top` A/B.
- `alu_opcode` out 3, `alu_logic_sel` out 2: to `alu_top`.
- `alu_result` in 8: from `alu_top`, combinational on `alu_*`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: downstream accepts result.
- `rsp_result` out 8: captured ALU result.
- `rsp_opcode` out 3: opcode that produced `rsp_result`.
- `fifo_count` out clog2(DEPTH)+1: occupied FIFO entries, 0..DEPTH.
- `rsp_err` out 1: only with `ALU_ISSUE_DIV0_FLAG_EN`, described under Configuration.

## Operation
- Push: a command enters the FIFO when `cmd_valid && cmd_ready`. `cmd_ready = (fifo_count != DEPTH)`, with no same-cycle pop bypass.
- FSM states and transitions:
  - IDLE: `rsp_valid=0`. If FIFO is not empty, pop the head into the operand registers and go to EXEC.
  - EXEC: the operand registers drive `alu_*`. At the end of the cycle, capture `alu_result` into `rsp_result` and the opcode into `rsp_opcode`, set `rsp_valid=1`, and go to RESP.
  - RESP: hold `rsp_*` stable while `rsp_ready=0`. On `rsp_ready=1`:
    - If FIFO is not empty: pop the head into the operand registers in the same cycle, clear `rsp_valid`, and go to EXEC.
    - Otherwise: clear `rsp_valid` and go to IDLE.
- `alu_*` always reflect the operand registers. They keep the last command's values after completion and never glitch mid-EXEC.
- Simultaneous push and pop: `fifo_count` is unchanged. Push on full is ignored because `cmd_ready=0`. Pop on empty never occurs.
- Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Results are passed through unmodified, with no arithmetic in this block. Commands complete strictly in acceptance order.

## Timing
- Reset values: `cmd_ready=1`, `rsp_valid=0`, `rsp_result=8'h00`, `rsp_opcode=3'b000`, `alu_a=alu_b=4'h0`, `alu_opcode=3'b000`, `alu_logic_sel=2'b00`, `fifo_count=0`, `rsp_err=0`. FSM resets to IDLE.
- Latency: a command accepted at edge N into an empty, idle block is popped at N+1 and gives `rsp_valid=1` after edge N+2.
- Throughput with `rsp_ready` held high: one result every 2 cycles.
- Total capacity: DEPTH buffered commands plus 1 in flight.
- Reset asserted mid-operation: all state clears immediately. Buffered and in-flight commands are discarded, and no response is emitted for them.

## Configuration
- `ALU_ISSUE_DIV0_FLAG_EN` defined:
  - `rsp_err` exists.
  - It is captured in EXEC as `(opcode==3'b011 || opcode==3'b111) && B==4'h0` and held with `rsp_result`.
  - The result is still the ALU's value, e.g. 0xFF for DIV by 0.
- Not defined: the `rsp_err` port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `OP_ADD`, `OP_SUB`, `OP_LOGIC`, `OP_DIV`, `OP_MUL`, `OP_ROL`, `OP_ROR`, `OP_MOD`;
  - the logic_sel constants;
  - the 13-bit command struct `{a, b, opcode, logic_sel}`;
  - the FSM state enum `{IDLE, EXEC, RESP}`.
- One sub-module, `alu_cmd_fifo`: parameterised DEPTH-entry synchronous FIFO with push/pop/full/empty/count.

## Test plan
- ADD A=3, B=4 with `rsp_ready=1` → `rsp_valid` 2 cycles after accept, `rsp_result=0x07`, `rsp_opcode=000`.
- Stream MUL F×F, DIV 8/2, ROR 1101 by 1 back-to-back → results 0xE1, 0x04, 0x0E in order, one every 2 cycles.
- Hold `rsp_ready=0` and offer 6 commands → 5 accepted, `fifo_count=4`, `cmd_ready=0`. Release `rsp_ready` → all 5 drain in order and `cmd_ready` returns high after the first pop.
- DIV 5/0 and MOD 9/0 → `rsp_result=0xFF` for DIV. With the macro, `rsp_err=1` for both and `rsp_err=0` for MOD 9/4 (result 0x01).
- Deassert `rst_n` during RESP with 3 commands queued → all outputs immediately at their reset values, and no stale response after release.
- Push a command on the same cycle as a pop, with `fifo_count=2` → count stays 2, and pointer wrap past DEPTH preserves order.
